// File: rtl/bht_table_if.sv
// Bus bundle for bht_table: lookup request/response, resolved-branch update,
// and the handshake with the external predictor FSM stage.
//   master : lookup/update requester and FSM stage (drives requests, fsm_new_state)
//   slave  : bht_table (drives lookup response and FSM-stage inputs)
// Optional macro BHT_STATS_EN adds the stat_upd/stat_hit counter outputs.
interface bht_table_if #(
    parameter int unsigned PC_W = 32
);
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_ready;
    logic            pred_taken;
    logic [1:0]      pred_state;

    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;

    logic            fsm_result;
    logic            fsm_strob;
    logic [1:0]      fsm_state;
    logic [1:0]      fsm_new_state;

`ifdef BHT_STATS_EN
    logic [15:0]     stat_upd;
    logic [15:0]     stat_hit;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, fsm_new_state,
        input  pred_ready, pred_taken, pred_state, fsm_result, fsm_strob, fsm_state,
        input  stat_upd, stat_hit
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, fsm_new_state,
        output pred_ready, pred_taken, pred_state, fsm_result, fsm_strob, fsm_state,
        output stat_upd, stat_hit
    );
`else
    modport master (
        output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, fsm_new_state,
        input  pred_ready, pred_taken, pred_state, fsm_result, fsm_strob, fsm_state
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, fsm_new_state,
        output pred_ready, pred_taken, pred_state, fsm_result, fsm_strob, fsm_state
    );
`endif
endinterface

// File: rtl/bht_table.sv
// Branch history table: 2^INDEX_W entries of 2-bit predictor state indexed by
// pc[INDEX_W+1:2]. Serves one-cycle lookups and a two-stage update path that
// hands the stored state to an external FSM stage and writes back its result.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bht_table_if.slave
//                pred_valid/pred_pc in, pred_ready/pred_taken/pred_state out
//                upd_valid/upd_pc/upd_taken in
//                fsm_strob/fsm_result/fsm_state out (combinational from stage U)
//                fsm_new_state in (combinational from the FSM stage)
// Optional macro BHT_STATS_EN: adds saturating 16-bit stat_upd/stat_hit outputs.
module bht_table #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned PC_W    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    bht_table_if.slave   bus
);

    localparam int unsigned ENTRIES = 2 ** INDEX_W;

    logic [1:0]         table_q [ENTRIES];

    logic               u_valid_q, u_valid_d;
    logic [INDEX_W-1:0] u_idx_q, u_idx_d;
    logic               u_res_q, u_res_d;

    logic               pred_ready_q, pred_ready_d;
    logic [1:0]         pred_state_q, pred_state_d;

    logic [INDEX_W-1:0] pred_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic               unused_pc;

    assign pred_idx  = bus.pred_pc[INDEX_W+1:2];
    assign upd_idx   = bus.upd_pc[INDEX_W+1:2];
    assign unused_pc = ^{bus.pred_pc, bus.upd_pc};

    // Next-state for update stage U and the lookup response
    always_comb begin
        u_valid_d    = bus.upd_valid;
        u_idx_d      = upd_idx;
        u_res_d      = bus.upd_taken;
        pred_ready_d = bus.pred_valid;
        pred_state_d = pred_state_q;
        if (bus.pred_valid) begin
            // The write landing on this edge is not yet in the table; take it directly
            if (u_valid_q && (u_idx_q == pred_idx)) begin
                pred_state_d = bus.fsm_new_state;
            end else begin
                pred_state_d = table_q[pred_idx];
            end
        end
    end

    // Update stage U and lookup response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_valid_q    <= 1'b0;
            u_idx_q      <= '0;
            u_res_q      <= 1'b0;
            pred_ready_q <= 1'b0;
            pred_state_q <= 2'd0;
        end else begin
            u_valid_q    <= u_valid_d;
            u_idx_q      <= u_idx_d;
            u_res_q      <= u_res_d;
            pred_ready_q <= pred_ready_d;
            pred_state_q <= pred_state_d;
        end
    end

    // Table storage; write-back of the FSM stage result at the end of stage U
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= 2'd0;
            end
        end else if (u_valid_q) begin
            table_q[u_idx_q] <= bus.fsm_new_state;
        end
    end

    assign bus.pred_ready = pred_ready_q;
    assign bus.pred_state = pred_state_q;
    assign bus.pred_taken = pred_state_q[1];
    assign bus.fsm_strob  = u_valid_q;
    assign bus.fsm_result = u_res_q;
    assign bus.fsm_state  = table_q[u_idx_q];

`ifdef BHT_STATS_EN
    logic [15:0] stat_upd_q, stat_upd_d;
    logic [15:0] stat_hit_q, stat_hit_d;
    logic        hit_c;

    // Saturating counters of updates and of updates whose stored prediction was right
    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_hit_d = stat_hit_q;
        hit_c      = u_valid_q && (table_q[u_idx_q][1] == u_res_q);
        if (u_valid_q && (stat_upd_q != 16'hFFFF)) begin
            stat_upd_d = stat_upd_q + 16'd1;
        end
        if (hit_c && (stat_hit_q != 16'hFFFF)) begin
            stat_hit_d = stat_hit_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_upd_q <= 16'd0;
            stat_hit_q <= 16'd0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_hit_q <= stat_hit_d;
        end
    end

    assign bus.stat_upd = stat_upd_q;
    assign bus.stat_hit = stat_hit_q;
`endif

endmodule

// File: tb/tb_bht_table.sv
// Scoreboard bench for bht_table; the bench also plays the external FSM stage.
module tb_bht_table;

    localparam int unsigned INDEX_W = 4;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned ENTRIES = 2 ** INDEX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bht_table_if #(.PC_W(PC_W)) bus ();

    bht_table #(.INDEX_W(INDEX_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference predictor FSM: 0=strong NT, 1=weak NT, 2=weak T, 3=strong T
    function automatic logic [1:0] fsm_next(input logic [1:0] s, input logic t);
        if (t) return (s == 2'd0) ? 2'd1 : 2'd3;
        return (s == 2'd3) ? 2'd2 : 2'd0;
    endfunction

    assign bus.fsm_new_state = fsm_next(bus.fsm_state, bus.fsm_result);

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] model_tab [ENTRIES];
    logic [1:0] exp_pred_q [$];
    logic [1:0] exp_st_q [$];
    logic       exp_res_q [$];
    logic [1:0] last_pred = 2'd0;
`ifdef BHT_STATS_EN
    int m_upd = 0;
    int m_hit = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) model_tab[i] = 2'd0;
        exp_pred_q.delete();
        exp_st_q.delete();
        exp_res_q.delete();
        last_pred = 2'd0;
`ifdef BHT_STATS_EN
        m_upd = 0;
        m_hit = 0;
`endif
    endtask

    // One clock of stimulus; lookups see every earlier update, updates apply in order
    task automatic cycle(input logic pv, input logic [PC_W-1:0] ppc,
                         input logic uv, input logic [PC_W-1:0] upc, input logic ut);
        int pi;
        int ui;
        bus.pred_valid = pv;
        bus.pred_pc    = ppc;
        bus.upd_valid  = uv;
        bus.upd_pc     = upc;
        bus.upd_taken  = ut;
        pi = int'(ppc[INDEX_W+1:2]);
        ui = int'(upc[INDEX_W+1:2]);
        if (pv) exp_pred_q.push_back(model_tab[pi]);
        if (uv) begin
            exp_st_q.push_back(model_tab[ui]);
            exp_res_q.push_back(ut);
`ifdef BHT_STATS_EN
            m_upd++;
            if (model_tab[ui][1] == ut) m_hit++;
`endif
            model_tab[ui] = fsm_next(model_tab[ui], ut);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [PC_W-1:0] rand_pc();
        logic [PC_W-1:0] p;
        logic [3:0]      hot;
        p = PC_W'($urandom());
        if ($urandom_range(0, 1) == 1) begin
            hot = 4'($urandom_range(0, 3));
            p[INDEX_W+1:2] = hot;
        end
        return p;
    endfunction

    // Monitor: pops and compares whenever the DUT presents a response
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pred_ready) begin
                if (exp_pred_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pred_unexpected: got pred_ready=1 required no response at %0t", $time);
                end else begin
                    last_pred = exp_pred_q.pop_front();
                    check("pred_state", int'(bus.pred_state), int'(last_pred));
                    check("pred_taken", int'(bus.pred_taken), int'(last_pred[1]));
                end
            end else begin
                check("pred_state_hold", int'(bus.pred_state), int'(last_pred));
            end
            if (bus.fsm_strob) begin
                if (exp_st_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fsm_unexpected: got fsm_strob=1 required no strobe at %0t", $time);
                end else begin
                    check("fsm_state", int'(bus.fsm_state), int'(exp_st_q.pop_front()));
                    check("fsm_result", int'(bus.fsm_result), int'(exp_res_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_pred_ready"}, int'(bus.pred_ready), 0);
        check({tag, "_pred_state"}, int'(bus.pred_state), 0);
        check({tag, "_pred_taken"}, int'(bus.pred_taken), 0);
        check({tag, "_fsm_strob"},  int'(bus.fsm_strob), 0);
        check({tag, "_fsm_result"}, int'(bus.fsm_result), 0);
        check({tag, "_fsm_state"},  int'(bus.fsm_state), 0);
`ifdef BHT_STATS_EN
        check({tag, "_stat_upd"}, int'(bus.stat_upd), 0);
        check({tag, "_stat_hit"}, int'(bus.stat_hit), 0);
`endif
    endtask

    initial begin
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;

        // Lookup after reset
        cycle(1'b1, 32'h40, 1'b0, '0, 1'b0);
        idle(2);

        // Spaced taken updates, then a lookup of the same PC
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 32'h44, 1'b1);
            idle(2);
        end
        cycle(1'b1, 32'h44, 1'b0, '0, 1'b0);
        idle(2);

        // Back-to-back updates to one entry
        cycle(1'b0, '0, 1'b1, 32'h48, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h48, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h48, 1'b0);
        idle(2);
        cycle(1'b1, 32'h48, 1'b0, '0, 1'b0);
        idle(2);

        // Lookup on the edge where the write lands (bypass)
        cycle(1'b0, '0, 1'b1, 32'h4C, 1'b1);
        cycle(1'b1, 32'h4C, 1'b0, '0, 1'b0);
        idle(2);

        // Reset asserted while an update to entry 5 is in stage U
        cycle(1'b0, '0, 1'b1, 32'h14, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h14, 1'b1);
        bus.upd_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        #1;
        check_reset_values("midrst_hold");
        rst_n = 1'b1;
        cycle(1'b1, 32'h14, 1'b0, '0, 1'b0);
        idle(2);

        // Four updates with exactly one stored prediction matching the outcome
        cycle(1'b0, '0, 1'b1, 32'h04, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h04, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h04, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'h08, 1'b1);
        idle(2);
`ifdef BHT_STATS_EN
        check("stat_upd_4", int'(bus.stat_upd), m_upd);
        check("stat_hit_1", int'(bus.stat_hit), m_hit);
`endif

        // Random concurrent lookups and updates
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)), rand_pc(),
                  1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)));
        end
        idle(3);

`ifdef BHT_STATS_EN
        check("stat_upd_rand", int'(bus.stat_upd), m_upd);
        check("stat_hit_rand", int'(bus.stat_hit), m_hit);
        // Drive the update counter past its ceiling
        for (int i = 0; i < 65540; i++) begin
            cycle(1'b0, '0, 1'b1, rand_pc(), 1'($urandom_range(0, 1)));
        end
        idle(3);
        check("stat_upd_sat", int'(bus.stat_upd), (m_upd > 65535) ? 65535 : m_upd);
        check("stat_hit_sat", int'(bus.stat_hit), (m_hit > 65535) ? 65535 : m_hit);
`endif

        check("pred_queue_drained", exp_pred_q.size(), 0);
        check("fsm_queue_drained", exp_st_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
